// File: rtl/game_phase_ctrl_pkg.sv
// Shared phase encodings, frame-count defaults and small helpers for the
// playfield sequencer and the draw/motion blocks that consume its flags.
package game_phase_ctrl_pkg;

    // Phase encodings, also exported on the phase debug port.
    localparam logic [2:0] PH_INIT  = 3'd0;
    localparam logic [2:0] PH_SERVE = 3'd1;
    localparam logic [2:0] PH_PLAY  = 3'd2;
    localparam logic [2:0] PH_DEAD  = 3'd3;
    localparam logic [2:0] PH_OVER  = 3'd4;

    // Frame-count defaults, shared so the renderer and motion blocks agree.
    localparam int DEF_LIVES        = 3;
    localparam int DEF_SERVE_FRAMES = 30;
    localparam int DEF_DEAD_FRAMES  = 60;
    localparam int DEF_OVER_FRAMES  = 180;
    localparam int DEF_FLASH_FRAMES = 8;

    localparam int FCNT_W  = 8;
    localparam int LEVEL_W = 4;
    localparam int LIVES_W = 2;

    // Level counter saturates at its maximum instead of wrapping.
    function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl);
        return (lvl == {LEVEL_W{1'b1}}) ? lvl : lvl + 1'b1;
    endfunction

    // Phases in which frame ticks advance the frame counter.
    function automatic logic is_timed(input logic [2:0] ph);
        return (ph == PH_SERVE) || (ph == PH_DEAD) || (ph == PH_OVER);
    endfunction

endpackage

// File: rtl/game_phase_ctrl_if.sv
// Event inputs and phase flag outputs of the playfield sequencer.
// master: the sequencer itself; slave: timing source and flag consumers.
interface game_phase_ctrl_if;
    import game_phase_ctrl_pkg::*;

    logic                 frame_tick;
    logic                 start_btn;
    logic                 ball_lost;
    logic                 bricks_clear;

    logic                 init;
    logic                 dead;
    logic                 border_on;
    logic                 play_en;
    logic                 ball_reset;
    logic                 level_up;
    logic [LIVES_W-1:0]   lives;
    logic [LEVEL_W-1:0]   level;
    logic [2:0]           phase;

    modport master (
        input  frame_tick, start_btn, ball_lost, bricks_clear,
        output init, dead, border_on, play_en, ball_reset, level_up,
               lives, level, phase
    );

    modport slave (
        output frame_tick, start_btn, ball_lost, bricks_clear,
        input  init, dead, border_on, play_en, ball_reset, level_up,
               lives, level, phase
    );

endinterface

// File: rtl/game_phase_ctrl_frame_timer.sv
// Loadable frame-tick counter. `done` flags the tick that brings the count
// to the compare value, so a phase using it lasts exactly cmp ticks.
module game_phase_ctrl_frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    input  logic [W-1:0] cmp,
    output logic [W-1:0] cnt_nxt,
    output logic         done
);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    // done depends only on the current count and tick, never on clr, so the
    // state machine can use it to decide transitions without a loop.
    always_comb begin
        cnt_inc = cnt + 1'b1;
        done    = tick && (cnt_inc == cmp);
        cnt_nxt = cnt;
        if (clr)
            cnt_nxt = '0;
        else if (load)
            cnt_nxt = load_val;
        else if (tick)
            cnt_nxt = cnt_inc;
    end

    // Count register; clear has priority over load and tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/game_phase_ctrl.sv
// Frame-level game phase sequencer: attract, serve, play, death, game over.
// All outputs are registered from next-state values so they change together
// with the phase register.
module game_phase_ctrl
    import game_phase_ctrl_pkg::*;
#(
    parameter int LIVES        = DEF_LIVES,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int DEAD_FRAMES  = DEF_DEAD_FRAMES,
    parameter int OVER_FRAMES  = DEF_OVER_FRAMES,
    parameter int FLASH_FRAMES = DEF_FLASH_FRAMES
) (
    input  logic             clk,
    input  logic             rst,
    game_phase_ctrl_if.master bus
);

    logic [2:0]          state, state_nxt;
    logic                start_q, start_ev;
    logic [LIVES_W-1:0]  lives_q, lives_nxt;
    logic [LEVEL_W-1:0]  level_q, level_nxt;
    logic                ball_reset_nxt, level_up_nxt;
    logic                init_q, dead_q, border_q, play_q, ball_reset_q, level_up_q;
    logic                border_nxt;

    logic                tick_en, clr, done;
    logic [FCNT_W-1:0]   cmp, cnt_nxt, flash_idx;

    // Start is an event only on a 0->1 transition of the debounced level.
    assign start_ev = bus.start_btn && !start_q;

    // Frames advance only in the timed phases.
    assign tick_en = bus.frame_tick && is_timed(state);

    // One counter is shared; its terminal value depends on the phase.
    always_comb begin
        cmp = '0;
        case (state)
            PH_SERVE: cmp = FCNT_W'(SERVE_FRAMES);
            PH_DEAD:  cmp = FCNT_W'(DEAD_FRAMES);
            PH_OVER:  cmp = FCNT_W'(OVER_FRAMES);
            default:  cmp = '0;
        endcase
    end

    // Phase transitions and the lives/level/pulse values that go with them.
    always_comb begin
        state_nxt      = state;
        lives_nxt      = lives_q;
        level_nxt      = level_q;
        ball_reset_nxt = 1'b0;
        level_up_nxt   = 1'b0;
        case (state)
            PH_INIT: begin
                if (start_ev) begin
                    state_nxt      = PH_SERVE;
                    lives_nxt      = LIVES_W'(LIVES);
                    level_nxt      = '0;
                    ball_reset_nxt = 1'b1;
                end
            end
            PH_SERVE: begin
                if (done)
                    state_nxt = PH_PLAY;
            end
            PH_PLAY: begin
                // A cleared board beats a lost ball in the same cycle.
                if (bus.bricks_clear) begin
                    state_nxt      = PH_SERVE;
                    level_nxt      = level_inc(level_q);
                    level_up_nxt   = 1'b1;
                    ball_reset_nxt = 1'b1;
                end else if (bus.ball_lost) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_nxt = lives_q - 1'b1;
                        state_nxt = PH_DEAD;
                    end else begin
                        lives_nxt = '0;
                        state_nxt = PH_OVER;
                    end
                end
            end
            PH_DEAD: begin
                if (done) begin
                    state_nxt      = PH_SERVE;
                    ball_reset_nxt = 1'b1;
                end
            end
            PH_OVER: begin
                // A start press only returns to attract; it never starts a game.
                if (start_ev || done)
                    state_nxt = PH_INIT;
            end
            default: state_nxt = PH_INIT;
        endcase
    end

    // Any phase change restarts the frame count, even when a tick coincides.
    assign clr = (state_nxt != state);

    game_phase_ctrl_frame_timer #(.W(FCNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (1'b0),
        .load_val ('0),
        .tick     (tick_en),
        .cmp      (cmp),
        .cnt_nxt  (cnt_nxt),
        .done     (done)
    );

    // Border blinks in DEAD with a half-period of FLASH_FRAMES, starting lit.
    always_comb begin
        flash_idx  = cnt_nxt / FCNT_W'(FLASH_FRAMES);
        border_nxt = (state_nxt == PH_DEAD) ? !flash_idx[0] : 1'b1;
    end

    // Phase, lives, level and start edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PH_INIT;
            start_q <= 1'b0;
            lives_q <= LIVES_W'(LIVES);
            level_q <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= bus.start_btn;
            lives_q <= lives_nxt;
            level_q <= level_nxt;
        end
    end

    // Registered phase flags and one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q       <= 1'b1;
            dead_q       <= 1'b0;
            border_q     <= 1'b1;
            play_q       <= 1'b0;
            ball_reset_q <= 1'b0;
            level_up_q   <= 1'b0;
        end else begin
            init_q       <= (state_nxt == PH_INIT);
            dead_q       <= (state_nxt == PH_DEAD) || (state_nxt == PH_OVER);
            border_q     <= border_nxt;
            play_q       <= (state_nxt == PH_PLAY);
            ball_reset_q <= ball_reset_nxt;
            level_up_q   <= level_up_nxt;
        end
    end

    assign bus.init       = init_q;
    assign bus.dead       = dead_q;
    assign bus.border_on  = border_q;
    assign bus.play_en    = play_q;
    assign bus.ball_reset = ball_reset_q;
    assign bus.level_up   = level_up_q;
    assign bus.lives      = lives_q;
    assign bus.level      = level_q;
    assign bus.phase      = state;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl: a vector table for the main game flow
// plus hand-written sequences for saturation, game over, timeout and reset.
module tb_game_phase_ctrl;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    game_phase_ctrl_if gp ();

    game_phase_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (gp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {phase, lives, level, init, dead, border_on, play_en, ball_reset, level_up}
    typedef struct {
        logic        ft, st, bl, bc;
        int          rep;
        logic [14:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic logic [14:0] ex(input logic [2:0] ph, input logic [1:0] lv,
                                       input logic [3:0] lvl, input logic in, input logic dd,
                                       input logic bo, input logic pe, input logic br,
                                       input logic lu);
        return {ph, lv, lvl, in, dd, bo, pe, br, lu};
    endfunction

    function automatic logic [14:0] outs();
        return {gp.phase, gp.lives, gp.level, gp.init, gp.dead, gp.border_on,
                gp.play_en, gp.ball_reset, gp.level_up};
    endfunction

    task automatic chk(input string name, input logic [14:0] act, input logic [14:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs; returns just after the sampling edge.
    task automatic cyc(input logic ft, input logic st, input logic bl, input logic bc);
        gp.frame_tick   = ft;
        gp.start_btn    = st;
        gp.ball_lost    = bl;
        gp.bricks_clear = bc;
        @(posedge clk);
        #1;
        gp.frame_tick   = 1'b0;
        gp.ball_lost    = 1'b0;
        gp.bricks_clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic ft, input logic st, input logic bl, input logic bc,
                                input int rep, input logic [14:0] e, input string name);
        vec_t v;
        v.ft = ft; v.st = st; v.bl = bl; v.bc = bc; v.rep = rep; v.exp = e; v.name = name;
        return v;
    endfunction

    localparam logic [14:0] RST_OUTS = {3'd0, 2'd3, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [3:0] exp_lvl;

        // Main flow table: each row is applied rep times, checked after the last.
        vq.push_back(mk(0,1,0,0,  1, ex(1,3,0,0,0,1,0,1,0), "start_serve"));
        vq.push_back(mk(0,1,0,0,  1, ex(1,3,0,0,0,1,0,0,0), "ball_reset_1cyc"));
        vq.push_back(mk(1,0,0,0, 29, ex(1,3,0,0,0,1,0,0,0), "serve_29"));
        vq.push_back(mk(1,0,0,0,  1, ex(2,3,0,0,0,1,1,0,0), "serve_30_play"));
        vq.push_back(mk(0,0,1,0,  1, ex(3,2,0,0,1,1,0,0,0), "lost_dead"));
        vq.push_back(mk(1,0,0,0,  7, ex(3,2,0,0,1,1,0,0,0), "dead_t7_on"));
        vq.push_back(mk(1,0,0,0,  1, ex(3,2,0,0,1,0,0,0,0), "dead_t8_off"));
        vq.push_back(mk(1,0,0,0,  7, ex(3,2,0,0,1,0,0,0,0), "dead_t15_off"));
        vq.push_back(mk(1,0,0,0,  1, ex(3,2,0,0,1,1,0,0,0), "dead_t16_on"));
        vq.push_back(mk(1,0,0,0, 43, ex(3,2,0,0,1,0,0,0,0), "dead_t59"));
        vq.push_back(mk(1,0,0,0,  1, ex(1,2,0,0,0,1,0,1,0), "dead_t60_serve"));
        vq.push_back(mk(0,0,0,0,  1, ex(1,2,0,0,0,1,0,0,0), "serve_idle"));
        vq.push_back(mk(1,0,0,0, 30, ex(2,2,0,0,0,1,1,0,0), "serve_play2"));
        vq.push_back(mk(0,0,1,1,  1, ex(1,2,1,0,0,1,0,1,1), "both_bc_wins"));
        vq.push_back(mk(0,0,0,0,  1, ex(1,2,1,0,0,1,0,0,0), "pulses_drop"));
        vq.push_back(mk(0,0,0,1,  1, ex(1,2,1,0,0,1,0,0,0), "serve_ign_bc"));
        vq.push_back(mk(0,0,1,0,  1, ex(1,2,1,0,0,1,0,0,0), "serve_ign_bl"));
        vq.push_back(mk(0,1,0,0,  1, ex(1,2,1,0,0,1,0,0,0), "serve_ign_st"));
        vq.push_back(mk(1,0,0,0, 30, ex(2,2,1,0,0,1,1,0,0), "serve_play3"));
        vq.push_back(mk(0,0,1,0,  1, ex(3,1,1,0,1,1,0,0,0), "lost_dead2"));
        vq.push_back(mk(1,0,0,0, 60, ex(1,1,1,0,0,1,0,1,0), "dead_serve2"));
        vq.push_back(mk(1,0,0,0, 30, ex(2,1,1,0,0,1,1,0,0), "serve_play4"));
        vq.push_back(mk(0,0,1,0,  1, ex(4,0,1,0,1,1,0,0,0), "lost_over"));
        vq.push_back(mk(1,0,0,0,179, ex(4,0,1,0,1,1,0,0,0), "over_179"));
        vq.push_back(mk(0,1,0,0,  1, ex(0,0,1,1,0,1,0,0,0), "over_start_init"));
        vq.push_back(mk(0,1,0,0,  3, ex(0,0,1,1,0,1,0,0,0), "init_held"));
        vq.push_back(mk(0,0,0,0,  1, ex(0,0,1,1,0,1,0,0,0), "init_release"));
        vq.push_back(mk(0,1,0,0,  1, ex(1,3,0,0,0,1,0,1,0), "new_game"));
        vq.push_back(mk(0,0,0,0,  1, ex(1,3,0,0,0,1,0,0,0), "new_game_idle"));

        gp.frame_tick = 0; gp.start_btn = 0; gp.ball_lost = 0; gp.bricks_clear = 0;
        rst = 1'b1;
        #1;
        chk("reset_async", outs(), RST_OUTS);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_state", outs(), RST_OUTS);
        cyc(0,0,0,0);
        chk("idle_init", outs(), RST_OUTS);

        foreach (vq[i]) begin
            repeat (vq[i].rep) cyc(vq[i].ft, vq[i].st, vq[i].bl, vq[i].bc);
            chk(vq[i].name, outs(), vq[i].exp);
        end

        // Level saturates at 15; level_up still pulses each clear.
        for (int i = 0; i < 16; i++) begin
            exp_lvl = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            ticks(30);
            cyc(0,0,0,1);
            chk($sformatf("level_clear_%0d", i), outs(), ex(1,3,exp_lvl,0,0,1,0,1,1));
        end

        // Game over with start held high across the transition.
        ticks(30); cyc(0,0,1,0); ticks(60);
        ticks(30); cyc(0,0,1,0); ticks(60);
        ticks(30);
        cyc(0,1,0,0);
        chk("play_ign_start", outs(), ex(2,1,15,0,0,1,1,0,0));
        cyc(0,1,1,0);
        chk("over_held", outs(), ex(4,0,15,0,1,1,0,0,0));
        repeat (5) cyc(1,1,0,0);
        chk("over_held_stay", outs(), ex(4,0,15,0,1,1,0,0,0));
        cyc(0,0,0,0);
        cyc(0,1,0,0);
        chk("over_fresh_edge", outs(), ex(0,0,15,1,0,1,0,0,0));

        // OVER timeout after exactly 180 ticks.
        cyc(0,0,0,0);
        cyc(0,1,0,0);
        chk("restart", outs(), ex(1,3,0,0,0,1,0,1,0));
        ticks(30); cyc(0,0,1,0); ticks(60);
        ticks(30); cyc(0,0,1,0); ticks(60);
        ticks(30); cyc(0,0,1,0);
        ticks(179);
        chk("over_t179", outs(), ex(4,0,0,0,1,1,0,0,0));
        ticks(1);
        chk("over_t180_init", outs(), ex(0,0,0,1,0,1,0,0,0));

        // Reset in the middle of DEAD at tick 20.
        cyc(0,1,0,0);
        ticks(30);
        cyc(0,0,1,0);
        ticks(20);
        chk("dead_t20", outs(), ex(3,2,0,0,1,1,0,0,0));
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_dead", outs(), RST_OUTS);
        @(posedge clk);
        #3;
        rst = 1'b0;
        chk("rst_release", outs(), RST_OUTS);
        cyc(0,0,0,0);
        chk("post_rst_idle", outs(), RST_OUTS);
        cyc(0,1,0,0);
        chk("post_rst_start", outs(), ex(1,3,0,0,0,1,0,1,0));
        ticks(29);
        chk("post_rst_s29", outs(), ex(1,3,0,0,0,1,0,0,0));
        ticks(1);
        chk("post_rst_s30", outs(), ex(2,3,0,0,0,1,1,0,0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_phase_ctrl.md
Name: game_phase_ctrl

Overview:
Frame-level sequencer for the Arkanoid playfield. It owns the game phase (attract, serve, play, death, game over) and drives the shared phase flags consumed by the background/border renderer and the ball, paddle and brick logic: init, dead, border blink enable, play enable, and reload pulses. It sits between the VGA timing generator, which supplies the frame tick, and all draw_* and motion blocks.

Parameters:
LIVES, 3, lives granted at game start (1..3, fits 2 bits)
SERVE_FRAMES, 30, frames spent in SERVE before play resumes
DEAD_FRAMES, 60, frames of border blink after a lost ball
OVER_FRAMES, 180, frames shown in OVER before returning to INIT
FLASH_FRAMES, 8, frames per border blink half-period in DEAD

Ports:
clk  in  1  pixel/system clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame, from VGA timing (vsync start)
start_btn  in  1  synchronous level from the debounced start button
ball_lost  in  1  one-cycle pulse: ball passed bottom edge (TOP+MAXY)
bricks_clear  in  1  one-cycle pulse: last brick destroyed
init  out  1  high in INIT; feeds draw_back init
dead  out  1  high in DEAD and OVER; feeds draw_back dead
border_on  out  1  border draw enable (blinks in DEAD)
play_en  out  1  ball/paddle motion enable, high only in PLAY
ball_reset  out  1  one-cycle pulse on every entry to SERVE
level_up  out  1  one-cycle pulse when bricks_clear is accepted
lives  out  2  remaining lives
level  out  4  current level, saturating at 15
phase  out  3  encoded state, for debug/score display

Behaviour:
- Reset, async: state INIT, init=1, dead=0, border_on=1, play_en=0, ball_reset=0, level_up=0, lives=LIVES, level=0, frame counter=0, start edge register=0.
- All outputs are registered. Each output reflects the new state on the cycle after the transition edge.
- start_btn is edge-detected internally. A start event is a 0->1 transition sampled on clk; holding the button produces one event.
- frame counter, 8 bits: cleared on every state entry, incremented on frame_tick in SERVE, DEAD and OVER. A timed state exits on the clk edge that samples its Nth frame_tick, so it is exactly N ticks long.
- States (phase encoding):
  - INIT=0: wait for start event. Then go to SERVE with lives=LIVES, level=0, ball_reset pulse.
  - SERVE=1: after SERVE_FRAMES ticks, go to PLAY. ball_lost and bricks_clear are ignored.
  - PLAY=2: play_en=1.
    - bricks_clear: level_up pulse, level+1 (saturating), go to SERVE, ball_reset pulse, lives unchanged.
    - ball_lost with lives>1: lives-1, go to DEAD.
    - ball_lost with lives==1: lives=0, go to OVER.
    - Both in the same cycle: bricks_clear wins and ball_lost is dropped.
  - DEAD=3: dead=1. border_on = NOT bit of (frame counter / FLASH_FRAMES), so it starts on. After DEAD_FRAMES ticks, go to SERVE with a ball_reset pulse.
  - OVER=4: dead=1, border_on=1. Exits to INIT after OVER_FRAMES ticks, or immediately on a start event. The start event goes to INIT, not directly to a new game.
- Start events outside INIT and OVER are ignored.
- Event pulses arriving together with frame_tick: the event takes priority and the counter clears.
- Unused phase codes 5-7 recover to INIT on the next clk.
- rst asserted mid-game aborts immediately to reset values. No pulse outputs fire during or on release of rst.

Decomposition:
- The shared def.v include adds the phase encodings as localparams: PH_INIT, PH_SERVE, PH_PLAY, PH_DEAD, PH_OVER.
- Frame-count defaults move into def.v so that draw_back and motion blocks agree on them.
- Sub-module: frame_timer, a loadable 8-bit frame-tick counter with clear and a terminal flag `done` for a compare value N. It is instantiated once; the compare value is muxed by state.

Test Plan:
- Reset then start_btn 0->1 -> one cycle later phase=1, ball_reset=1 for exactly 1 cycle, lives=3. After 30 frame_ticks phase=2, play_en=1.
- In PLAY, pulse ball_lost -> lives=2, phase=3, dead=1. border_on=1 for ticks 0-7 and 0 for ticks 8-15. After 60 ticks phase=1 with a ball_reset pulse.
- ball_lost three times from a fresh game -> lives=0, phase=4. start_btn held high through the transition causes no exit; a fresh 0->1 edge -> phase=0, init=1.
- ball_lost and bricks_clear in the same cycle -> level=1, level_up one pulse, lives unchanged, phase=1.
- 16 bricks_clear events -> level saturates at 15, with level_up still pulsing each time.
- rst asserted mid-DEAD at tick 20 -> outputs at reset values immediately. After release, a start event gives a normal 30-tick SERVE.
